// File: rtl/bitlog_pkg.sv
// Shared types and constants for the bit-log dump path.
package bitlog_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int BYTES_PER_ENTRY     = 4;
  localparam int DEFAULT_INDEX_WIDTH = 9;

endpackage

// File: rtl/bitlog_dumper_word_serializer.sv
// Holds one 32-bit log word and offers it downstream byte by byte,
// little-endian, with a valid/ready handshake.
module word_serializer
  import bitlog_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] loadWord,
  input  logic        txReady,
  output logic        txValid,
  output logic [7:0]  txData,
  output logic        lastAccepted
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_ENTRY - 1);

  logic [31:0] holdingReg;
  logic [1:0]  byteCountReg;
  logic        validReg;
  logic        transfer;

  assign transfer     = validReg & txReady;
  assign lastAccepted = transfer && (byteCountReg == LAST_BYTE);
  assign txValid      = validReg;
  // Data is forced to zero whenever nothing is offered.
  assign txData       = validReg ? holdingReg[{byteCountReg, 3'b000} +: 8] : 8'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      holdingReg   <= '0;
      byteCountReg <= '0;
      validReg     <= 1'b0;
    end else if (load) begin
      holdingReg   <= loadWord;
      byteCountReg <= '0;
      validReg     <= 1'b1;
    end else if (transfer) begin
      if (byteCountReg == LAST_BYTE) begin
        validReg <= 1'b0;
      end else begin
        byteCountReg <= byteCountReg + 2'd1;
      end
    end
  end

endmodule

// File: rtl/bitlog_dumper.sv
// Walks the length log from index 0 up to the latched count and streams
// every 32-bit entry out as four bytes.
module bitlog_dumper
  import bitlog_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH:0]   entryCount,
  output logic                   readEnable,
  output logic [INDEX_WIDTH-1:0] readIndex,
  input  logic [31:0]            readData,
  input  logic                   readWait,
  output logic                   txValid,
  output logic [7:0]             txData,
  input  logic                   txReady,
  output logic                   busy,
  output logic                   done
);

  localparam logic [INDEX_WIDTH:0] MAX_COUNT = {1'b1, {INDEX_WIDTH{1'b0}}};

  state_t                 stateReg, stateNext;
  logic [INDEX_WIDTH-1:0] indexReg, indexNext;
  logic [INDEX_WIDTH:0]   countReg, countNext;
  logic                   load;
  logic                   lastAccepted;
  logic                   lastEntry;

  assign lastEntry = ({1'b0, indexReg} == (countReg - 1'b1));

  always_comb begin
    stateNext = stateReg;
    indexNext = indexReg;
    countNext = countReg;
    load      = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) begin
          indexNext = '0;
          countNext = (entryCount > MAX_COUNT) ? MAX_COUNT : entryCount;
          stateNext = (entryCount == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (!readWait) begin
          load      = 1'b1;
          stateNext = SEND;
        end
      end
      SEND: begin
        // Going back through SEND always leaves readEnable low for a cycle.
        if (lastAccepted) begin
          if (lastEntry) begin
            stateNext = FINISH;
          end else begin
            indexNext = indexReg + 1'b1;
            stateNext = READ;
          end
        end
      end
      FINISH: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      indexReg <= '0;
      countReg <= '0;
    end else begin
      stateReg <= stateNext;
      indexReg <= indexNext;
      countReg <= countNext;
    end
  end

  assign readEnable = (stateReg == READ);
  assign readIndex  = indexReg;
  assign busy       = (stateReg != IDLE);
  assign done       = (stateReg == FINISH);

  word_serializer serializer (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .loadWord     (readData),
    .txReady      (txReady),
    .txValid      (txValid),
    .txData       (txData),
    .lastAccepted (lastAccepted)
  );

endmodule

// File: tb/tb_bitlog_dumper.sv
// Scoreboard bench for bitlog_dumper: directed dumps against a small log model.
module tb_bitlog_dumper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  entryCount = '0;
  logic        readEnable;
  logic [8:0]  readIndex;
  logic [31:0] readData;
  logic        readWait;
  logic        txValid;
  logic [7:0]  txData;
  logic        txReady = 1'b1;
  logic        busy;
  logic        done;

  logic [31:0] logMem [0:511];
  logic [7:0]  expQ [$];
  int          waitLen = 0;
  int          waitCnt = 0;
  int          cycleCnt = 0;
  int          nChecks = 0;
  int          nFails = 0;
  int          bytesSeen = 0;
  int          readsDone = 0;
  int          doneSeen = 0;
  int          lastXferCycle = 0;
  int          lastReadIdx = 0;
  int          byteBase = 0;
  int          readBase = 0;
  int          doneBase = 0;
  logic        prevStall = 1'b0;
  logic [7:0]  prevData = '0;

  always #5 clk = ~clk;

  bitlog_dumper #(.INDEX_WIDTH(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .entryCount (entryCount),
    .readEnable (readEnable),
    .readIndex  (readIndex),
    .readData   (readData),
    .readWait   (readWait),
    .txValid    (txValid),
    .txData     (txData),
    .txReady    (txReady),
    .busy       (busy),
    .done       (done)
  );

  // Log model: data follows the index, wait is held for waitLen cycles of each read.
  assign readData = logMem[readIndex];
  assign readWait = readEnable && (waitCnt < waitLen);

  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    waitCnt  <= readEnable ? waitCnt + 1 : 0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each transfer, tracks reads and done pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (prevStall) begin
        check("hold_valid", {31'd0, txValid}, 32'd1);
        check("hold_data", {24'd0, txData}, {24'd0, prevData});
      end
      if (txValid && txReady) begin
        bytesSeen++;
        lastXferCycle = cycleCnt;
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL unexpected_byte: got %02h, required no byte", txData);
        end else begin
          check("byte", {24'd0, txData}, {24'd0, expQ.pop_front()});
        end
      end
      if (readEnable && !readWait) begin
        check("read_index", {23'd0, readIndex}, readsDone - readBase);
        lastReadIdx = readIndex;
        readsDone++;
      end
      if (done) begin
        doneSeen++;
        if (bytesSeen > byteBase) check("done_latency", cycleCnt, lastXferCycle + 1);
      end
      prevStall = txValid && !txReady;
      prevData  = txData;
    end else begin
      prevStall = 1'b0;
    end
  end

  task automatic markBase();
    byteBase = bytesSeen;
    readBase = readsDone;
    doneBase = doneSeen;
  endtask

  task automatic pulseStart(input int cnt);
    @(posedge clk); #1;
    entryCount = 10'(cnt);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitBytes(input int n, input int budget);
    int i;
    i = 0;
    while ((bytesSeen - byteBase) < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    if ((bytesSeen - byteBase) < n) check("wait_bytes_timeout", bytesSeen - byteBase, n);
  endtask

  task automatic waitIdle(input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (busy) check("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_readEnable"}, {31'd0, readEnable}, 32'd0);
    check({tag, "_readIndex"}, {23'd0, readIndex}, 32'd0);
    check({tag, "_txValid"}, {31'd0, txValid}, 32'd0);
    check({tag, "_txData"}, {24'd0, txData}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) logMem[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 checkAllZero("in_reset");
    reset = 1'b1;
    @(negedge clk);
    checkAllZero("after_reset");

    // Two entries, txReady always high, latency checked
    logMem[0] = 32'h0000_0005;
    logMem[1] = 32'h1122_3344;
    expQ = {8'h05, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    markBase();
    pulseStart(2);
    check("latency_readEnable", {31'd0, readEnable}, 32'd1);
    @(posedge clk); #1;
    check("latency_txValid", {31'd0, txValid}, 32'd1);
    check("latency_txData", {24'd0, txData}, 32'h05);
    waitIdle(100);
    check("t1_bytes", bytesSeen - byteBase, 8);
    check("t1_done", doneSeen - doneBase, 1);
    check("t1_queue_empty", expQ.size(), 0);

    // Zero entries: FINISH straight away, and a start during done is ignored
    markBase();
    @(posedge clk); #1;
    entryCount = 10'd0;
    start = 1'b1;
    @(posedge clk); #1;
    check("t2_busy", {31'd0, busy}, 32'd1);
    check("t2_done", {31'd0, done}, 32'd1);
    entryCount = 10'd3;
    @(posedge clk); #1;
    start = 1'b0;
    check("t2_busy_after", {31'd0, busy}, 32'd0);
    check("t2_done_after", {31'd0, done}, 32'd0);
    repeat (4) @(posedge clk);
    #1 check("t2_still_idle", {31'd0, busy}, 32'd0);
    check("t2_done_count", doneSeen - doneBase, 1);
    check("t2_no_bytes", bytesSeen - byteBase, 0);

    // Backpressure on byte 2, with a slow log
    logMem[0] = 32'hA1B2_C3D4;
    expQ = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
    waitLen = 2;
    markBase();
    pulseStart(1);
    waitBytes(2, 50);
    txReady = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("t3_stall_valid", {31'd0, txValid}, 32'd1);
      check("t3_stall_data", {24'd0, txData}, 32'hB2);
    end
    @(posedge clk); #1;
    txReady = 1'b1;
    waitIdle(100);
    check("t3_bytes", bytesSeen - byteBase, 4);
    check("t3_done", doneSeen - doneBase, 1);

    // Oversized count clamps to 512 entries
    waitLen = 1;
    for (int i = 0; i < 512; i++) begin
      logMem[i] = i * 32'h0103_0507 + 32'h89AB_CDEF;
      for (int b = 0; b < 4; b++) expQ.push_back(logMem[i][8*b +: 8]);
    end
    markBase();
    pulseStart(600);
    waitIdle(10000);
    check("t4_bytes", bytesSeen - byteBase, 2048);
    check("t4_reads", readsDone - readBase, 512);
    check("t4_last_index", lastReadIdx, 511);
    check("t4_done", doneSeen - doneBase, 1);
    check("t4_queue_empty", expQ.size(), 0);

    // Reset in the middle of a three-entry dump, then restart
    waitLen = 0;
    logMem[0] = 32'h0102_0304;
    logMem[1] = 32'h0506_0708;
    logMem[2] = 32'h090A_0B0C;
    expQ = {8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05,
            8'h0C, 8'h0B, 8'h0A, 8'h09};
    markBase();
    pulseStart(3);
    waitBytes(6, 100);
    #1 reset = 1'b0;
    #1 checkAllZero("mid_reset");
    expQ.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_idle_busy", {31'd0, busy}, 32'd0);
    check("t5_idle_valid", {31'd0, txValid}, 32'd0);
    check("t5_bytes_before_reset", bytesSeen - byteBase, 6);
    check("t5_no_done", doneSeen - doneBase, 0);
    expQ = {8'h04, 8'h03, 8'h02, 8'h01};
    markBase();
    pulseStart(1);
    check("t5_restart_index", {23'd0, readIndex}, 32'd0);
    waitIdle(100);
    check("t5_restart_bytes", bytesSeen - byteBase, 4);
    check("t5_restart_done", doneSeen - doneBase, 1);

    // A start pulse mid-dump must not disturb the stream
    logMem[0] = 32'hDEAD_BEEF;
    logMem[1] = 32'h00FF_7F80;
    expQ = {8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h80, 8'h7F, 8'hFF, 8'h00};
    markBase();
    pulseStart(2);
    waitBytes(3, 50);
    entryCount = 10'd1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitIdle(100);
    check("t6_bytes", bytesSeen - byteBase, 8);
    check("t6_reads", readsDone - readBase, 2);
    check("t6_done", doneSeen - doneBase, 1);
    check("t6_queue_empty", expQ.size(), 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
